// File: rtl/hall_commutator_if.sv
// Signal bundle between the hall sensor pins, the phase drivers and hall_commutator.
// The period signal exists only when HALL_PERIOD_EN is defined.
interface hall_commutator_if #(
   parameter int CNT_W = 16,
   parameter int ERR_W = 8
`ifdef HALL_PERIOD_EN
   , parameter int PERIOD_W = 20
`endif
);
   logic             en;
   logic             dir;
   logic             brake;
   logic             clr_fault;
   logic [2:0]       hall;
   logic [2:0]       u;
   logic [2:0]       z;
   logic             fault;
   logic [CNT_W-1:0] hall_count;
   logic [ERR_W-1:0] err_count;
`ifdef HALL_PERIOD_EN
   logic [PERIOD_W-1:0] period;
`endif

   modport master (
      output en, dir, brake, clr_fault, hall,
      input  u, z, fault, hall_count, err_count
`ifdef HALL_PERIOD_EN
      , input period
`endif
   );

   modport slave (
      input  en, dir, brake, clr_fault, hall,
      output u, z, fault, hall_count, err_count
`ifdef HALL_PERIOD_EN
      , output period
`endif
   );
endinterface

// File: rtl/hall_commutator.sv
// Registered six-step BLDC commutator: synchronised and debounced hall decode, direction,
// coast/brake/fault modes, step and error counters. HALL_PERIOD_EN adds step-period measurement.
module hall_commutator #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 16,
   parameter int ERR_W           = 8
`ifdef HALL_PERIOD_EN
   , parameter int PERIOD_W      = 20
`endif
) (
   input  logic               clk,
   input  logic               rst_n,
   hall_commutator_if.slave   bus
);

   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_BRAKE, S_FAULT} state_e;

   function automatic logic valid_code(input logic [2:0] c);
      return (c != 3'b000) && (c != 3'b111);
   endfunction

   // Position of a valid code in the forward sequence 101,100,110,010,011,001.
   function automatic logic [2:0] code_idx(input logic [2:0] c);
      case (c)
         3'b101:  return 3'd0;
         3'b100:  return 3'd1;
         3'b110:  return 3'd2;
         3'b010:  return 3'd3;
         3'b011:  return 3'd4;
         3'b001:  return 3'd5;
         default: return 3'd0;
      endcase
   endfunction

   function automatic logic [2:0] next_idx(input logic [2:0] i);
      return (i == 3'd5) ? 3'd0 : i + 3'd1;
   endfunction

   logic [2:0]       sync1_q, sync2_q, cand_q, hq_q;
   logic             hv_q;
   logic [DB_W-1:0]  db_cnt_q;
   state_e           state_q, state_d;
   logic [2:0]       u_q, u_d, z_q, z_d;
   logic             fault_q;
   logic [CNT_W-1:0] hall_count_q;
   logic [ERR_W-1:0] err_count_q;

   logic             accept, counted, step_fwd, step_rev, illegal;
   logic [2:0]       idx_old, idx_new, u_fwd, z_fwd;

   assign accept   = (db_cnt_q == DB_MAX) && (cand_q != hq_q);
   assign idx_old  = code_idx(hq_q);
   assign idx_new  = code_idx(cand_q);
   assign counted  = accept && hv_q && valid_code(hq_q) && valid_code(cand_q);
   assign step_fwd = counted && (idx_new == next_idx(idx_old));
   assign step_rev = counted && (idx_old == next_idx(idx_new));
   assign illegal  = counted && !step_fwd && !step_rev;

   // NOTE: state is updated with <= so every flop samples pre-edge values, whatever the block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 3'b000;
         sync2_q  <= 3'b000;
         cand_q   <= 3'b000;
         hq_q     <= 3'b000;
         hv_q     <= 1'b0;
         db_cnt_q <= '0;
      end else begin
         sync1_q <= bus.hall;
         sync2_q <= sync1_q;
         if (sync2_q != cand_q) begin
            cand_q   <= sync2_q;
            db_cnt_q <= '0;
         end else if (db_cnt_q != DB_MAX) begin
            db_cnt_q <= db_cnt_q + 1'b1;
         end
         if (accept) begin
            hq_q <= cand_q;
            hv_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hall_count_q <= '0;
         err_count_q  <= '0;
      end else begin
         if (step_fwd)      hall_count_q <= hall_count_q + 1'b1;
         else if (step_rev) hall_count_q <= hall_count_q - 1'b1;
         if (illegal && (err_count_q != {ERR_W{1'b1}}))
            err_count_q <= err_count_q + 1'b1;
      end
   end

   // NOTE: every variable driven here gets a default first, so no path leaves one unassigned (no latch).
   always_comb begin
      state_d = state_q;
      if (hv_q && bus.en && !valid_code(hq_q)) begin
         state_d = S_FAULT;
      end else if (state_q == S_FAULT) begin
         if (bus.clr_fault && valid_code(hq_q)) state_d = S_IDLE;
      end else if (!hv_q || !bus.en) begin
         state_d = S_IDLE;
      end else if (bus.brake) begin
         state_d = S_BRAKE;
      end else begin
         state_d = S_RUN;
      end
   end

   always_comb begin
      u_fwd = 3'b000;
      z_fwd = 3'b111;
      case (hq_q)
         3'b101: begin u_fwd = 3'b100; z_fwd = 3'b001; end
         3'b100: begin u_fwd = 3'b100; z_fwd = 3'b010; end
         3'b110: begin u_fwd = 3'b010; z_fwd = 3'b100; end
         3'b010: begin u_fwd = 3'b010; z_fwd = 3'b001; end
         3'b011: begin u_fwd = 3'b001; z_fwd = 3'b010; end
         3'b001: begin u_fwd = 3'b001; z_fwd = 3'b100; end
         default: ;
      endcase
   end

   // Outputs follow the next state so u/z move on the same edge as the FSM, one clock after hq.
   always_comb begin
      u_d = 3'b000;
      z_d = 3'b111;
      case (state_d)
         S_BRAKE: z_d = 3'b000;
         S_RUN: begin
            z_d = z_fwd;
            u_d = bus.dir ? ~(u_fwd | z_fwd) : u_fwd;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         u_q     <= 3'b000;
         z_q     <= 3'b111;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         u_q     <= u_d;
         z_q     <= z_d;
         fault_q <= (state_d == S_FAULT);
      end
   end

   assign bus.u          = u_q;
   assign bus.z          = z_q;
   assign bus.fault      = fault_q;
   assign bus.hall_count = hall_count_q;
   assign bus.err_count  = err_count_q;

`ifdef HALL_PERIOD_EN
   logic [PERIOD_W-1:0] per_cnt_q, period_q;

   // Any acceptance restarts the timer; only a counted step publishes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         per_cnt_q <= '0;
         period_q  <= '0;
      end else begin
         if (step_fwd || step_rev) period_q <= per_cnt_q;
         if (accept)
            per_cnt_q <= PERIOD_W'(1);
         else if (per_cnt_q != {PERIOD_W{1'b1}})
            per_cnt_q <= per_cnt_q + 1'b1;
      end
   end

   assign bus.period = period_q;
`endif

endmodule

// File: tb/tb_hall_commutator.sv
// Directed-vector bench for hall_commutator: table of steady-state vectors plus hand sequences
// for latency, glitch rejection, direction change, fault exit and asynchronous reset.
module tb_hall_commutator;

   localparam int D        = 4;
   localparam int CNT_W    = 16;
   localparam int ERR_W    = 8;
   localparam int PERIOD_W = 20;
   localparam int HOLD     = 20;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   hall_commutator_if #(
      .CNT_W(CNT_W), .ERR_W(ERR_W)
`ifdef HALL_PERIOD_EN
      , .PERIOD_W(PERIOD_W)
`endif
   ) bus ();

   hall_commutator #(
      .DEBOUNCE_CYCLES(D), .CNT_W(CNT_W), .ERR_W(ERR_W)
`ifdef HALL_PERIOD_EN
      , .PERIOD_W(PERIOD_W)
`endif
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [2:0]       hall;
      logic             dir, en, brake, clr;
      logic [2:0]       u, z;
      logic             fault;
      logic [CNT_W-1:0] hc;
      logic [ERR_W-1:0] ec;
   } vec_t;

   vec_t vecs[22];

   function automatic vec_t mk(input logic [2:0] hall, input logic dir, en, brake, clr,
                               input logic [2:0] u, z, input logic fault,
                               input int hc, input int ec);
      vec_t v;
      v.hall = hall; v.dir = dir; v.en = en; v.brake = brake; v.clr = clr;
      v.u = u; v.z = z; v.fault = fault;
      v.hc = CNT_W'(hc); v.ec = ERR_W'(ec);
      return v;
   endfunction

   // Packs {u, z, fault, hall_count, err_count} for a single comparison.
   function automatic logic [63:0] pack(input logic [2:0] u, z, input logic f,
                                        input logic [CNT_W-1:0] hc, input logic [ERR_W-1:0] ec);
      return 64'({u, z, f, hc, ec});
   endfunction

   function automatic logic [63:0] observed();
      return pack(bus.u, bus.z, bus.fault, bus.hall_count, bus.err_count);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply(input int i);
      bus.hall = vecs[i].hall; bus.dir = vecs[i].dir; bus.en = vecs[i].en;
      bus.brake = vecs[i].brake; bus.clr_fault = vecs[i].clr;
      step(HOLD);
      check($sformatf("vec%0d", i), observed(),
            pack(vecs[i].u, vecs[i].z, vecs[i].fault, vecs[i].hc, vecs[i].ec));
   endtask

   initial begin
      //                hall    dir   en    brk   clr   u       z       f     hc ec
      vecs[0]  = mk(3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 3'b010, 1'b0, 1, 0);
      vecs[1]  = mk(3'b110, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 3'b100, 1'b0, 2, 0);
      vecs[2]  = mk(3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 3'b001, 1'b0, 3, 0);
      vecs[3]  = mk(3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 3'b010, 1'b0, 4, 0);
      vecs[4]  = mk(3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 3'b100, 1'b0, 5, 0);
      vecs[5]  = mk(3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 3'b001, 1'b0, 6, 0);
      vecs[6]  = mk(3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 3'b100, 1'b0, 5, 0);
      vecs[7]  = mk(3'b011, 1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 3'b010, 1'b0, 4, 0);
      vecs[8]  = mk(3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 3'b001, 1'b0, 3, 0);
      vecs[9]  = mk(3'b110, 1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 3'b100, 1'b0, 2, 0);
      vecs[10] = mk(3'b100, 1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 3'b010, 1'b0, 1, 0);
      vecs[11] = mk(3'b101, 1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 3'b001, 1'b0, 0, 0);
      // illegal jumps, brake, coast, fault
      vecs[12] = mk(3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 3'b001, 1'b0, 0, 1);
      vecs[13] = mk(3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 3'b010, 1'b0, 1, 1);
      vecs[14] = mk(3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 3'b001, 1'b0, 1, 2);
      vecs[15] = mk(3'b101, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1, 2);
      vecs[16] = mk(3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 3'b001, 1'b0, 1, 2);
      vecs[17] = mk(3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b111, 1'b0, 2, 2);
      vecs[18] = mk(3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 3'b010, 1'b0, 2, 2);
      vecs[19] = mk(3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b111, 1'b1, 2, 2);
      vecs[20] = mk(3'b111, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 3'b111, 1'b1, 2, 2);
      vecs[21] = mk(3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b111, 1'b1, 2, 2);

      bus.en = 1'b0; bus.dir = 1'b0; bus.brake = 1'b0; bus.clr_fault = 1'b0; bus.hall = 3'b000;
      step(2);
      check("reset", observed(), pack(3'b000, 3'b111, 1'b0, '0, '0));
      rst_n = 1'b1;
      step(3);

      // Pin-to-output latency: first sampling edge is the next one, u/z move on edge D+4.
      bus.en = 1'b1; bus.hall = 3'b101;
      step(D + 3);
      check("latency_before", observed(), pack(3'b000, 3'b111, 1'b0, '0, '0));
      step(1);
      check("latency_at", observed(), pack(3'b100, 3'b001, 1'b0, '0, '0));

      for (int i = 0; i < 12; i++) apply(i);

      // dir change takes effect on the next clock
      bus.dir = 1'b0;
      step(1);
      check("dir_to_fwd", observed(), pack(3'b100, 3'b001, 1'b0, '0, '0));
      bus.dir = 1'b1;
      step(1);
      check("dir_to_rev", observed(), pack(3'b010, 3'b001, 1'b0, '0, '0));
      bus.dir = 1'b0;

      // glitch shorter than the debounce window is ignored
      bus.hall = 3'b110;
      step(3);
      bus.hall = 3'b101;
      step(HOLD);
      check("glitch", observed(), pack(3'b100, 3'b001, 1'b0, '0, '0));

      for (int i = 12; i < 22; i++) apply(i);

      // fault exit goes through IDLE, then RUN on the following clock
      bus.clr_fault = 1'b1;
      step(1);
      check("clr_to_idle", observed(), pack(3'b000, 3'b111, 1'b0, CNT_W'(2), ERR_W'(2)));
      bus.clr_fault = 1'b0;
      step(1);
      check("idle_to_run", observed(), pack(3'b001, 3'b010, 1'b0, CNT_W'(2), ERR_W'(2)));

      // asynchronous reset between clock edges
      #3;
      rst_n = 1'b0;
      bus.hall = 3'b101;
      #1;
      check("async_reset", observed(), pack(3'b000, 3'b111, 1'b0, '0, '0));
`ifdef HALL_PERIOD_EN
      check("async_reset_period", 64'(bus.period), 64'd0);
`endif
      step(2);
      rst_n = 1'b1;

      // two forward steps exactly 100 clocks apart
      step(HOLD);
      bus.hall = 3'b100;
      step(100);
      bus.hall = 3'b110;
      step(HOLD);
      check("post_reset_steps", observed(), pack(3'b010, 3'b100, 1'b0, CNT_W'(2), '0));
`ifdef HALL_PERIOD_EN
      check("period", 64'(bus.period), 64'd100);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
